// File: rtl/sysarr_data_skew_if.sv
// Handshake and array-facing bus of the systolic-array data skewer.
// The skewer takes the slave side; whoever feeds it and watches its outputs takes master.
interface sysarr_data_skew_if #(
  parameter int ROWS   = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic                     start;
  logic [CNT_W-1:0]         len;
  logic [ROWS*DATA_W-1:0]   vec_in;
  logic                     vec_valid;
  logic                     vec_ready;
  logic [ROWS*DATA_W-1:0]   datain;
  logic                     active;
  logic                     busy;
  logic                     done;

  modport master (
    output start, len, vec_in, vec_valid,
    input  vec_ready, datain, active, busy, done
  );

  modport slave (
    input  start, len, vec_in, vec_valid,
    output vec_ready, datain, active, busy, done
  );
endinterface

// File: rtl/sysarr_data_skew.sv
// Feeds the systolic array's left edge, delaying row r by r extra cycles so that each
// row's data meets the `active` wavefront as it ripples down the left column.
module sysarr_data_skew #(
  parameter int ROWS   = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sysarr_data_skew_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DRAIN_W = $clog2(ROWS + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((ROWS > 1) ? (ROWS - 2) : 0);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
  logic                 active_q;
  logic                 accept;

  assign accept = (state_q == FEED) && bus.vec_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drainCnt_q  <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drainCnt_q  <= drainCnt_d;
      active_q    <= accept;
    end
  end

  // DRAIN holds for ROWS-1 cycles so the deepest lane's last byte leaves the pipeline.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drainCnt_d  = drainCnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            remaining_d = bus.len;
            state_d     = FEED;
          end else begin
            state_d = DONE;
          end
        end
      end
      FEED: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            drainCnt_d = '0;
            state_d    = (ROWS > 1) ? DRAIN : DONE;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drainCnt_d = drainCnt_q + DRAIN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.vec_ready = (state_q == FEED);
  assign bus.busy      = (state_q == FEED) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.active    = active_q;

  // Lane r is a (1+r)-deep shift register; idle cycles push zeros so bubbles stay row-aligned.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] pipe_q [r+1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= r; s++) begin
          pipe_q[s] <= '0;
        end
      end else begin
        pipe_q[0] <= accept ? bus.vec_in[r*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= r; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    assign bus.datain[r*DATA_W +: DATA_W] = pipe_q[r];
  end

endmodule

// File: tb/tb_sysarr_data_skew.sv
// Directed bench for the 2-row data skewer; each scenario is a cycle table of
// driven inputs and the outputs expected in that same cycle.
module tb_sysarr_data_skew;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sysarr_data_skew_if #(.ROWS(2), .DATA_W(8), .CNT_W(8)) bus ();

  sysarr_data_skew #(.ROWS(2), .DATA_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // eFlags = {vec_ready, busy, done, active}; eData = {lane1, lane0}
  typedef struct packed {
    logic        st;
    logic [7:0]  ln;
    logic        vv;
    logic [15:0] vi;
    logic [3:0]  eFlags;
    logic [15:0] eData;
  } row_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    logic [19:0] obs;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.vec_in    = '0;
    bus.vec_valid = 1'b0;
    @(posedge clk);
    #1;
    obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=%h", obs, 20'h0);
    end
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    row_t tbl [7] = '{
      '{1'b1, 8'd3, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'h0201, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'h0403, 4'b1101, 16'h0001},
      '{1'b0, 8'd0, 1'b1, 16'h0605, 4'b1101, 16'h0203},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0101, 16'h0405},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0010, 16'h0600},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL basic_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_bubble();
    row_t tbl [7] = '{
      '{1'b1, 8'd2, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'h0A0B, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'hEEEE, 4'b1101, 16'h000B},
      '{1'b0, 8'd0, 1'b1, 16'h0C0D, 4'b1100, 16'h0A00},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0101, 16'h000D},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0010, 16'h0C00},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL bubble_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_zero_len();
    row_t tbl [4] = '{
      '{1'b1, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'hFFFF, 4'b0010, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL zero_len_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignored_start();
    row_t tbl [7] = '{
      '{1'b1, 8'd2, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b1, 8'd5, 1'b1, 16'h1122, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'h3344, 4'b1101, 16'h0022},
      '{1'b0, 8'd0, 1'b1, 16'h5566, 4'b0101, 16'h1144},
      '{1'b0, 8'd0, 1'b1, 16'h5566, 4'b0010, 16'h3300},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL ignored_start_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    row_t tbl [6] = '{
      '{1'b1, 8'd1, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'h5A6B, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0101, 16'h006B},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0010, 16'h5A00},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    bus.start = 1'b1; bus.len = 8'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.len = 8'd0;
    bus.vec_valid = 1'b1; bus.vec_in = 16'h1234;
    @(posedge clk);
    #1;
    bus.vec_in = 16'h5678;
    obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
    checks++;
    if (obs !== 20'hD0034) begin
      failures++;
      $display("[TB] FAIL reset_mid_pre got=%h exp=%h", obs, 20'hD0034);
    end
    #2 reset = 1'b1;
    #1;
    obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_immediate got=%h exp=%h", obs, 20'h0);
    end
    bus.vec_valid = 1'b0; bus.vec_in = '0;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      checks++;
      if (obs !== 20'h0) begin
        failures++;
        $display("[TB] FAIL reset_mid_idle_c%0d got=%h exp=%h", i, obs, 20'h0);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL reset_mid_after_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t tbl [9] = '{
      '{1'b1, 8'd1, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'hAABB, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0101, 16'h00BB},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0010, 16'hAA00},
      '{1'b1, 8'd1, 1'b0, 16'h0000, 4'b0000, 16'h0000},
      '{1'b0, 8'd0, 1'b1, 16'hCCDD, 4'b1100, 16'h0000},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0101, 16'h00DD},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0010, 16'hCC00},
      '{1'b0, 8'd0, 1'b0, 16'h0000, 4'b0000, 16'h0000}
    };
    logic [19:0] obs, exp;
    for (int i = 0; i < $size(tbl); i++) begin
      obs = {bus.vec_ready, bus.busy, bus.done, bus.active, bus.datain};
      exp = {tbl[i].eFlags, tbl[i].eData};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back_c%0d rdy/busy/done/act/data got=%h exp=%h", i, obs, exp);
      end
      bus.start = tbl[i].st; bus.len = tbl[i].ln;
      bus.vec_valid = tbl[i].vv; bus.vec_in = tbl[i].vi;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_bubble();
    test_zero_len();
    test_ignored_start();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
